// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Purpose  : Instruction-decode stage of a 5-stage pipelined MIPS core.
//            Holds the register file (with optional same-cycle write-back
//            bypass), main control decode, sign extension, load-use hazard
//            detection, jump redirect and the ID/EX pipeline register.
// Ports    : clk, rst_n (sync, active-low)
//            if_valid/if_pc/if_inst  -> instruction held in IF/ID
//            id_ready                <- ID consumes IF/ID this cycle
//            flush, ex_ready         -> EX kill / EX back-pressure
//            wb_we/wb_rd/wb_data     -> register write-back from MEM/WB
//            jump_valid/jump_target  <- combinational IF redirect
//            id_ex_*                 <- registered ID/EX contents
// Revision : 1.0 - initial release
// ============================================================================
module id_stage #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_inst,
    output logic            id_ready,
    input  logic            flush,
    input  logic            ex_ready,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            jump_valid,
    output logic [XLEN-1:0] jump_target,
    output logic            id_ex_valid,
    output logic [XLEN-1:0] id_ex_pc,
    output logic [XLEN-1:0] id_ex_rs_data,
    output logic [XLEN-1:0] id_ex_rt_data,
    output logic [XLEN-1:0] id_ex_imm,
    output logic [4:0]      id_ex_rs,
    output logic [4:0]      id_ex_rt,
    output logic [4:0]      id_ex_wreg,
    output logic [3:0]      id_ex_ex,
    output logic [2:0]      id_ex_mem,
    output logic [1:0]      id_ex_wb,
    output logic            id_ex_illegal
);

    localparam int RA = $clog2(REG_COUNT);

    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;
    localparam logic [5:0] C_OP_ADDI  = 6'h08;
    localparam logic [5:0] C_OP_J     = 6'h02;

    logic [5:0]      w_opcode;
    logic [RA-1:0]   w_rs_idx;
    logic [RA-1:0]   w_rt_idx;
    logic [RA-1:0]   w_wb_idx;
    logic            w_rs_byp;
    logic            w_rt_byp;
    logic [XLEN-1:0] w_rs_data;
    logic [XLEN-1:0] w_rt_data;
    logic [3:0]      w_ex;
    logic [2:0]      w_mem;
    logic [1:0]      w_wb;
    logic            w_illegal;
    logic            w_rt_use;
    logic            w_load_use;
    logic            w_issue_valid;
    logic [4:0]      w_wreg;
    logic            w_seg_carry;
    logic [XLEN-29:0] w_jump_hi;

    logic [XLEN-1:0] r_rf [REG_COUNT];

    assign w_opcode = if_inst[31:26];
    // Index bits above RA alias onto the implemented registers.
    assign w_rs_idx = if_inst[21 +: RA];
    assign w_rt_idx = if_inst[16 +: RA];
    assign w_wb_idx = wb_rd[RA-1:0];

    // ------------------------------------------------------------------
    // Register file: r0 is hard-wired to zero, write-back is never
    // blocked by stall or flush, only by reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_rf[i] <= '0;
            end
        end else if (wb_we && (w_wb_idx != '0)) begin
            r_rf[w_wb_idx] <= wb_data;
        end
    end

    generate
        if (WB_BYPASS) begin : g_bypass
            assign w_rs_byp = wb_we && (w_wb_idx == w_rs_idx);
            assign w_rt_byp = wb_we && (w_wb_idx == w_rt_idx);
        end else begin : g_no_bypass
            assign w_rs_byp = 1'b0;
            assign w_rt_byp = 1'b0;
        end
    endgenerate

    assign w_rs_data = (w_rs_idx == '0) ? '0 : (w_rs_byp ? wb_data : r_rf[w_rs_idx]);
    assign w_rt_data = (w_rt_idx == '0) ? '0 : (w_rt_byp ? wb_data : r_rf[w_rt_idx]);

    // ------------------------------------------------------------------
    // Main control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_ex      = 4'b0000;
        w_mem     = 3'b000;
        w_wb      = 2'b00;
        w_illegal = 1'b0;
        w_rt_use  = 1'b0;
        case (w_opcode)
            C_OP_RTYPE: begin
                w_ex     = 4'b1010;
                w_wb     = 2'b10;
                w_rt_use = 1'b1;
            end
            C_OP_LW: begin
                w_ex  = 4'b0100;
                w_mem = 3'b010;
                w_wb  = 2'b11;
            end
            C_OP_SW: begin
                w_ex     = 4'b0100;
                w_mem    = 3'b001;
                w_rt_use = 1'b1;
            end
            C_OP_BEQ: begin
                w_ex     = 4'b0001;
                w_mem    = 3'b100;
                w_rt_use = 1'b1;
            end
            C_OP_ADDI: begin
                w_ex = 4'b0100;
                w_wb = 2'b10;
            end
            C_OP_J: begin
                w_ex = 4'b0000;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_wreg = w_ex[3] ? if_inst[15:11] : if_inst[20:16];

    // rs is compared for every opcode; a spurious match can only cost a
    // one-cycle stall, never a wrong result.
    assign w_load_use = if_valid && id_ex_valid && id_ex_mem[1] && (id_ex_wreg != 5'd0) &&
                        ((id_ex_wreg == if_inst[25:21]) ||
                         (w_rt_use && (id_ex_wreg == if_inst[20:16])));

    assign id_ready   = rst_n && (flush || (ex_ready && !w_load_use));
    assign jump_valid = rst_n && if_valid && (w_opcode == C_OP_J) && ex_ready &&
                        !w_load_use && !flush;

    // Upper bits of pc+4: adding 4 carries out of bit 27 only when
    // pc[27:2] is all ones, so the low bits never need a full adder.
    assign w_seg_carry = &if_pc[27:2];
    assign w_jump_hi   = if_pc[XLEN-1:28] + {{(XLEN-29){1'b0}}, w_seg_carry};
    assign jump_target = {w_jump_hi, if_inst[25:0], 2'b00};

    // An accepted jump is fully handled by the redirect; it travels as a bubble.
    assign w_issue_valid = if_valid && (w_opcode != C_OP_J);

    // ------------------------------------------------------------------
    // ID/EX pipeline register: reset > flush > hold > bubble > load
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_ex_valid   <= 1'b0;
            id_ex_pc      <= '0;
            id_ex_rs_data <= '0;
            id_ex_rt_data <= '0;
            id_ex_imm     <= '0;
            id_ex_rs      <= '0;
            id_ex_rt      <= '0;
            id_ex_wreg    <= '0;
            id_ex_ex      <= '0;
            id_ex_mem     <= '0;
            id_ex_wb      <= '0;
            id_ex_illegal <= 1'b0;
        end else if (flush || (ex_ready && w_load_use)) begin
            id_ex_valid   <= 1'b0;
            id_ex_ex      <= '0;
            id_ex_mem     <= '0;
            id_ex_wb      <= '0;
            id_ex_illegal <= 1'b0;
        end else if (ex_ready) begin
            id_ex_valid   <= w_issue_valid;
            id_ex_pc      <= if_pc;
            id_ex_rs_data <= w_rs_data;
            id_ex_rt_data <= w_rt_data;
            id_ex_imm     <= {{(XLEN-16){if_inst[15]}}, if_inst[15:0]};
            id_ex_rs      <= if_inst[25:21];
            id_ex_rt      <= if_inst[20:16];
            id_ex_wreg    <= w_wreg;
            id_ex_ex      <= w_issue_valid ? w_ex : 4'b0000;
            id_ex_mem     <= w_issue_valid ? w_mem : 3'b000;
            id_ex_wb      <= w_issue_valid ? w_wb : 2'b00;
            id_ex_illegal <= w_issue_valid ? w_illegal : 1'b0;
        end
    end

endmodule
`default_nettype wire
